// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bus lock sharing one registered memory port between two requesters.
// Grant to mem_addr in 1 cycle; write done at grant+2; read done with data at grant+2+MEM_LAT.
module mem_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 1,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  input  logic              req0_lock,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              rr, cur, own_vld, own_idx;
  logic [LAT_W-1:0]  lat_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              elig0, elig1, grant0, grant1, grant, own_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we, sel_lock;

  // A lock owner excludes the other side; on a tie the side that is not rr wins.
  always_comb begin
    elig0  = req0_valid && (!own_vld || !own_idx);
    elig1  = req1_valid && (!own_vld || own_idx);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state == IDLE) begin
      if (elig0 && elig1) begin
        grant0 = rr;
        grant1 = !rr;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign grant      = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sel_addr   = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata  = grant1 ? req1_wdata : req0_wdata;
  assign sel_we     = grant1 ? req1_we    : req0_we;
  assign sel_lock   = grant1 ? req1_lock  : req0_lock;
  assign own_valid  = own_idx ? req1_valid : req0_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = mem_we ? IDLE : WAIT;
      WAIT:    if (lat_cnt == LAT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      rr         <= 1'b1;
      cur        <= 1'b0;
      own_vld    <= 1'b0;
      own_idx    <= 1'b0;
      lat_cnt    <= '0;
      to_cnt     <= '0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      mem_we    <= 1'b0;
      if (grant) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        mem_we    <= sel_we;
        cur       <= grant1;
        rr        <= grant1;
        own_vld   <= sel_lock;
        own_idx   <= grant1;
        to_cnt    <= '0;
      end else if (state == IDLE && own_vld && !own_valid) begin
        // Release lands at the edge after the count is reached, so the
        // other side is granted one cycle later.
        if (to_cnt == TO_W'(LOCK_TIMEOUT)) begin
          own_vld <= 1'b0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
      if (state == ISSUE) begin
        if (mem_we) begin
          if (cur) req1_done <= 1'b1;
          else     req0_done <= 1'b1;
        end else begin
          lat_cnt <= LAT_W'(MEM_LAT);
        end
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
        if (lat_cnt == LAT_W'(1)) begin
          if (cur) begin
            req1_rdata <= mem_rdata;
            req1_done  <= 1'b1;
          end else begin
            req0_rdata <= mem_rdata;
            req0_done  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single 16-bit-data, 24-bit-address memory port between two requesters. Requester 0 is the core's fetch/load/store path; requester 1 is the I/O/DMA path. Arbitration is round-robin with an optional bus lock so a requester can run atomic multi-access sequences. Transactions are registered onto the memory port, and read data is returned after a fixed memory latency.

Parameters:
ADDR_W, 24, address width of the requesters and the memory port
DATA_W, 16, data width
MEM_LAT, 1, cycles from mem_addr presented to mem_rdata valid (>=1)
LOCK_TIMEOUT, 8, idle cycles after which a held lock is forcibly released (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a transaction pending
req0_addr  input  ADDR_W  requester 0 address
req0_wdata  input  DATA_W  requester 0 write data
req0_we  input  1  1 = write, 0 = read
req0_lock  input  1  keep ownership after this transaction
req0_ready  output  1  grant; transaction accepted this cycle
req0_done  output  1  one-cycle pulse; transaction complete
req0_rdata  output  DATA_W  read data, valid with req0_done on reads
req1_*  (same eight signals as req0_*)  requester 1
mem_addr  output  ADDR_W  memory address (registered)
mem_wdata  output  DATA_W  memory write data (registered)
mem_we  output  1  memory write enable (registered, one-cycle pulse)
mem_rdata  input  DATA_W  memory read data

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - state=IDLE; mem_addr=0, mem_wdata=0, mem_we=0.
  - reqN_ready=0, reqN_done=0, reqN_rdata=0.
  - rr pointer=1, so requester 0 wins the first tie; lock owner=none; timeout counter=0.
- Requester rules: hold addr/wdata/we/lock stable while valid=1 and ready=0. A transfer occurs when valid and ready are both 1 at a rising edge.
- FSM states:
  - IDLE: reqN_ready is combinational and is asserted for at most one requester.
  - Eligibility: if a lock owner exists, only the owner is eligible. Otherwise, when both are valid, grant the requester that is not the rr pointer; when one is valid, grant it.
  - On a grant edge: capture addr/wdata/we/lock into the mem_* registers, set rr pointer = granted index, go to ISSUE.
  - ISSUE (1 cycle): mem_addr/mem_wdata/mem_we are driven from the registers.
    - Write: mem_we=1 for exactly this cycle; next state IDLE; reqN_done pulses in the following cycle.
    - Read: mem_we=0; next state WAIT with counter=MEM_LAT.
  - WAIT: decrement the counter each cycle. In the cycle where the counter equals 1, sample mem_rdata into reqN_rdata, pulse reqN_done next cycle, and return to IDLE.
- Latency, with grant at cycle T:
  - mem_addr valid at T+1.
  - Write done at T+2.
  - Read done with data at T+2+MEM_LAT.
  - A new grant may occur in the same cycle as done.
- mem_addr and mem_wdata hold their last values when idle. mem_we is 0 outside ISSUE.
- reqN_rdata holds until the next read completion for that requester. Writes do not modify it.
- Lock:
  - If the captured lock bit=1, that requester becomes owner at the grant edge.
  - If it is 0 and that requester was owner, ownership is cleared.
  - While an owner exists and the state is IDLE with owner valid=0, the timeout counter increments. At LOCK_TIMEOUT the lock is released and the counter is cleared. The owner regains the lock only via a new grant with lock=1.
  - The counter resets on every owner grant.
- Simultaneous events:
  - A valid that drops before grant is a cancelled request, legal only if ready was 0.
  - Lock released by timeout and other requester valid in the same cycle: the grant to the other requester occurs the next cycle.
- Reset mid-transaction: the in-flight access is abandoned. No done pulse; mem_we falls immediately.
- Unknown state encoding: recover to IDLE.

Test Plan:
- Single read, MEM_LAT=1: req0 read at 0x000010, memory returns 0xBEEF. Expect req0_ready at T, mem_addr=0x000010 at T+1, req0_done=1 and req0_rdata=0xBEEF at T+3.
- Write: req1 write at 0x00ABCD with data 0x1234. Expect mem_we=1 only at T+1 with mem_addr=0x00ABCD and mem_wdata=0x1234, req1_done at T+2, req1_rdata unchanged.
- Contention: both requesters continuously valid after reset for 4 transactions. Expect grant order 0,1,0,1 and never both ready in one cycle.
- Lock: req0 issues 3 reads with lock=1 while req1 is continuously valid. Expect req1 not granted until after the req0 transaction with lock=0 completes.
- Lock timeout (LOCK_TIMEOUT=8): req0 grants with lock=1, then valid=0; req1 valid. Expect req1_ready exactly 9 cycles after req0 returns to IDLE.
- Reset mid-read (MEM_LAT=3): assert rst_n=0 in WAIT. Expect all outputs 0 and no done pulse; after release, a req0 read completes normally with correct data.
